// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter.
//   - FSM state codes (2-bit, legacy-compatible localparams)
//   - grant identifiers used for the round-robin memory bit
//   - watchdog counter width
package mem_arb_pkg;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] GRANT_P = 2'b01;
  localparam logic [1:0] GRANT_D = 2'b10;

  localparam logic GNT_P = 1'b0;
  localparam logic GNT_D = 1'b1;

  // Wide enough for any TIMEOUT up to 65535.
  localparam int WD_CNT_W = 16;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Watchdog for the shared memory port.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       pulse on entry to a grant; clears the counter
//   run         memory request outstanding; counter advances while high
//   timeout     sticky flag, set when the counter reaches TIMEOUT
// TIMEOUT = 0 disables the flag entirely. The counter saturates rather
// than wrapping, so a stuck port can never make the flag look fresh.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic timeout
);

  localparam logic [WD_CNT_W-1:0] LIMIT = TIMEOUT[WD_CNT_W-1:0];

  logic [WD_CNT_W-1:0] cnt;
  logic [WD_CNT_W-1:0] cnt_next;

  assign cnt_next = (cnt == '1) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else if (start) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt_next;
      // Flag rises on the same edge the count reaches TIMEOUT, i.e. after
      // exactly TIMEOUT cycles of an outstanding request.
      if ((LIMIT != '0) && (cnt_next == LIMIT)) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one block-wide SDRAM controller port between p_cache (read-only
// instruction fills) and d_cache (block reads and write-backs).
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   p_req/p_address               p_cache request, held until p_ready
//   p_data/p_ready                fill data and one-cycle completion pulse
//   d_req/d_we/d_address/d_wdata  d_cache request, held until d_ready
//   d_rdata/d_ready               read data and one-cycle completion pulse
//   mem_req/mem_we/mem_address/mem_wdata  registered request to controller
//   mem_rdata/mem_ready           controller response
//   arb_state                     debug: FSM state (IDLE/GRANT_P/GRANT_D)
//   arb_timeout                   debug: sticky watchdog flag
// Handshake: a requester raises x_req with stable inputs and holds it until
// x_ready. The request is captured on grant, so later changes (including
// dropping x_req) do not affect the transaction in flight. The controller
// sees mem_req high until it answers with a one-cycle mem_ready; mem_req
// falls combinationally in that same cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 64,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_req,
  input  logic [ADDR_W-1:0] p_address,
  output logic [DATA_W-1:0] p_data,
  output logic              p_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        arb_state,
  output logic              arb_timeout
);

  logic [1:0] state;
  logic       last_grant;
  logic       p_win;
  logic       d_win;
  logic       granted;

  // Arbitration decision, only meaningful in IDLE.
  always_comb begin
    p_win = 1'b0;
    d_win = 1'b0;
    if (state == IDLE) begin
      if (p_req && d_req) begin
        if (ARB_MODE == 1) begin
          d_win = 1'b1;
        end else if (last_grant == GNT_P) begin
          d_win = 1'b1;
        end else begin
          p_win = 1'b1;
        end
      end else if (p_req) begin
        p_win = 1'b1;
      end else if (d_req) begin
        d_win = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= GNT_P;
      mem_we      <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_win) begin
            state       <= GRANT_D;
            last_grant  <= GNT_D;
            mem_address <= d_address;
            mem_we      <= d_we;
            mem_wdata   <= d_wdata;
          end else if (p_win) begin
            state       <= GRANT_P;
            last_grant  <= GNT_P;
            mem_address <= p_address;
            mem_we      <= 1'b0;
          end
        end
        GRANT_P, GRANT_D: begin
          if (mem_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign granted   = (state == GRANT_P) || (state == GRANT_D);
  assign mem_req   = granted && !mem_ready;
  assign arb_state = state;

  // Read data is broadcast; only the ready pulse is steered.
  assign p_data  = mem_rdata;
  assign d_rdata = mem_rdata;
  assign p_ready = (state == GRANT_P) && mem_ready;
  assign d_ready = (state == GRANT_D) && mem_ready;

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (p_win || d_win),
    .run    (mem_req),
    .timeout(arb_timeout)
  );

endmodule
